// File: rtl/chain_code_pkg.sv
// Shared definitions for the Freeman chain code encoder/decoder pair.
// Direction convention: row = x, column = y; code 0 is east, codes go counter-clockwise.
// Optional feature macro used by the decoder: CHAIN_DECODER_AREA_EN.
package chain_code_pkg;

  localparam int DIM    = 64;
  localparam int AW     = 6;
  localparam int PW     = 12;
  localparam int AREA_W = 13;

  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_NW = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_SE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_PLOT   = 3'd2,
    ST_ACCEPT = 3'd3,
    ST_CHECK  = 3'd4,
    ST_AREA   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  // Row step for a code: north is row-1, south is row+1.
  function automatic logic signed [1:0] delta_row(input logic [2:0] code);
    case (code)
      DIR_NE, DIR_N, DIR_NW: delta_row = 2'sb11;
      DIR_SW, DIR_S, DIR_SE: delta_row = 2'sb01;
      default:               delta_row = 2'sb00;
    endcase
  endfunction

  // Column step for a code: east is col+1, west is col-1.
  function automatic logic signed [1:0] delta_col(input logic [2:0] code);
    case (code)
      DIR_E, DIR_NE, DIR_SE: delta_col = 2'sb01;
      DIR_NW, DIR_W, DIR_SW: delta_col = 2'sb11;
      default:               delta_col = 2'sb00;
    endcase
  endfunction

  // Number of set pixels in one bitmap row (0..DIM).
  function automatic logic [AW:0] popcount(input logic [DIM-1:0] row);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < DIM; i++) begin
      cnt = cnt + {{AW{1'b0}}, row[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/contour_bitmap.sv
// DIM x DIM bitmap register array: whole-row clear, single-pixel set and a
// registered row read. The array itself is not reset; it is cleared by the
// decoder at the start of each decode.
// With CHAIN_DECODER_AREA_EN an extra combinational scan port feeds the area count.
module contour_bitmap
  import chain_code_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr_en_i,
  input  logic [AW-1:0]  clr_row_i,
  input  logic           set_en_i,
  input  logic [AW-1:0]  set_row_i,
  input  logic [AW-1:0]  set_col_i,
  input  logic [AW-1:0]  rd_addr_i,
  output logic [DIM-1:0] rd_data_o
`ifdef CHAIN_DECODER_AREA_EN
  ,
  input  logic [AW-1:0]  scan_addr_i,
  output logic [DIM-1:0] scan_data_o
`endif
);

  logic [DIM-1:0] mem_q [DIM];
  logic [DIM-1:0] rd_data_q;

  // Pixel storage: row clear and pixel set are never requested in the same cycle.
  always_ff @(posedge clk) begin
    if (clr_en_i) begin
      mem_q[clr_row_i] <= '0;
    end
    if (set_en_i) begin
      mem_q[set_row_i][set_col_i] <= 1'b1;
    end
  end

  // Registered readback; a same-cycle write to the row is seen one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef CHAIN_DECODER_AREA_EN
  assign scan_data_o = mem_q[scan_addr_i];
`endif

endmodule

// File: rtl/chain_code_decoder.sv
// Freeman chain code decoder: rebuilds a contour into a 64x64 bitmap from a
// start pixel and a stream of 3-bit codes.
// Optional macro CHAIN_DECODER_AREA_EN adds an AREA scan state that counts set
// pixels after the contour closes; without it the area output is tied to 0.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | zeroing bitmap rows 0..63, one per cycle
// PLOT   | marking the start pixel
// ACCEPT | taking codes, one per cycle, until code_last
// CHECK  | comparing final position with the start pixel
// AREA   | summing row popcounts (area build only)
// DONE   | decode finished, outputs held
// ERR    | out-of-bounds move or perimeter overflow, outputs held
module chain_code_decoder
  import chain_code_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AW-1:0]     start_x,
  input  logic [AW-1:0]     start_y,
  input  logic              code_valid,
  input  logic [2:0]        code,
  input  logic              code_last,
  output logic              code_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DIM-1:0]    rd_data,
  output logic              done,
  output logic              error,
  output logic              closed,
  output logic [PW-1:0]     perimeter,
  output logic [AREA_W-1:0] area
);

  state_e        state_q;
  logic [AW-1:0] cur_r_q, cur_c_q;
  logic [AW-1:0] start_r_q, start_c_q;
  logic [AW-1:0] row_cnt_q;
  logic [PW-1:0] perim_q;
  logic          error_q, closed_q;
`ifdef CHAIN_DECODER_AREA_EN
  logic [AREA_W-1:0] area_q;
  logic [DIM-1:0]    scan_data;
`endif

  logic signed [1:0] dr, dc;
  logic [AW:0]       nxt_r_ext, nxt_c_ext;
  logic              move_ok, perim_full;
  logic              set_en_d, clr_en_d;
  logic [AW-1:0]     set_row_d, set_col_d;

  // Candidate next position, one bit wider so that stepping off either edge
  // (0-1 wraps to all ones, DIM-1+1 reaches DIM) shows up in the top bit.
  assign dr         = delta_row(code);
  assign dc         = delta_col(code);
  assign nxt_r_ext  = {1'b0, cur_r_q} + {{(AW-1){dr[1]}}, dr};
  assign nxt_c_ext  = {1'b0, cur_c_q} + {{(AW-1){dc[1]}}, dc};
  assign move_ok    = !nxt_r_ext[AW] && !nxt_c_ext[AW];
  assign perim_full = &perim_q;

  // Bitmap write controls: clear sweep, start-pixel plot, or accepted legal move.
  always_comb begin
    clr_en_d  = (state_q == ST_CLEAR);
    set_en_d  = 1'b0;
    set_row_d = cur_r_q;
    set_col_d = cur_c_q;
    if (state_q == ST_PLOT) begin
      set_en_d = 1'b1;
    end else if (state_q == ST_ACCEPT && code_valid && move_ok && !perim_full) begin
      set_en_d  = 1'b1;
      set_row_d = nxt_r_ext[AW-1:0];
      set_col_d = nxt_c_ext[AW-1:0];
    end
  end

  contour_bitmap u_bitmap (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_en_i    (clr_en_d),
    .clr_row_i   (row_cnt_q),
    .set_en_i    (set_en_d),
    .set_row_i   (set_row_d),
    .set_col_i   (set_col_d),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data)
`ifdef CHAIN_DECODER_AREA_EN
    ,
    .scan_addr_i (row_cnt_q),
    .scan_data_o (scan_data)
`endif
  );

  // Decode sequencer: clear, plot, accept codes, check closure, optional area scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cur_r_q   <= '0;
      cur_c_q   <= '0;
      start_r_q <= '0;
      start_c_q <= '0;
      row_cnt_q <= '0;
      perim_q   <= '0;
      error_q   <= 1'b0;
      closed_q  <= 1'b0;
`ifdef CHAIN_DECODER_AREA_EN
      area_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            cur_r_q   <= start_x;
            cur_c_q   <= start_y;
            start_r_q <= start_x;
            start_c_q <= start_y;
            row_cnt_q <= '0;
            perim_q   <= '0;
            error_q   <= 1'b0;
            closed_q  <= 1'b0;
`ifdef CHAIN_DECODER_AREA_EN
            area_q    <= '0;
`endif
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          row_cnt_q <= row_cnt_q + 1'b1;
          if (row_cnt_q == AW'(DIM - 1)) begin
            state_q <= ST_PLOT;
          end
        end
        ST_PLOT: begin
          state_q <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (code_valid) begin
            if (perim_full || !move_ok) begin
              error_q <= 1'b1;
              state_q <= ST_ERR;
            end else begin
              cur_r_q <= nxt_r_ext[AW-1:0];
              cur_c_q <= nxt_c_ext[AW-1:0];
              perim_q <= perim_q + 1'b1;
              if (code_last) begin
                state_q <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          closed_q <= (cur_r_q == start_r_q) && (cur_c_q == start_c_q);
`ifdef CHAIN_DECODER_AREA_EN
          row_cnt_q <= '0;
          state_q   <= ST_AREA;
`else
          state_q   <= ST_DONE;
`endif
        end
`ifdef CHAIN_DECODER_AREA_EN
        ST_AREA: begin
          area_q    <= area_q + {{(AREA_W-AW-1){1'b0}}, popcount(scan_data)};
          row_cnt_q <= row_cnt_q + 1'b1;
          if (row_cnt_q == AW'(DIM - 1)) begin
            state_q <= ST_DONE;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign code_ready = (state_q == ST_ACCEPT);
  assign done       = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign error      = error_q;
  assign closed     = closed_q;
  assign perimeter  = perim_q;
`ifdef CHAIN_DECODER_AREA_EN
  assign area       = area_q;
`else
  assign area       = '0;
`endif

endmodule
